struct_out_fifo: RTL and testbench
==================================

STRUCT_OUT_FIFO -- requirements
Module: struct_out_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload data width in bits, at least 1.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, a power of two, at least 2.
REQ-003 SHALL have parameter SEQ_W, default 4: sequence-stamp width in bits, at least 1.
REQ-004 SHALL have parameter IDLE_VAL, default all ones (DATA_W bits): value o_data shows when the FIFO is empty.
REQ-005 SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_valid, input, 1 bit: producer offers i_data.
REQ-008 SHALL have port i_data, input, DATA_W bits: write payload.
REQ-009 SHALL have port o_ready, output, 1 bit: FIFO can accept a write.
REQ-010 SHALL have port o_valid, output, 1 bit: head entry is present.
REQ-011 SHALL have port o_data, output, DATA_W bits: head-entry data field.
REQ-012 SHALL have port o_seq, output, SEQ_W bits: head-entry sequence stamp.
REQ-013 SHALL have port i_ready, input, 1 bit: consumer takes the head entry.
REQ-014 SHALL have port o_count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-015 SHALL have port o_drop_cnt, output, 8 bits: saturating count of rejected writes.

Function
REQ-016 SHALL hold each entry as an unpacked record {data, seq}; o_data and o_seq SHALL be driven from the fields of the head record.
REQ-017 SHALL drive o_ready = (count < DEPTH) and o_valid = (count > 0), both purely from registered state.
REQ-018 SHALL accept a push on an edge where i_valid && o_ready: store {i_data, seq_ctr} at wr_ptr, increment wr_ptr modulo DEPTH, increment seq_ctr modulo 2^SEQ_W.
REQ-019 SHALL perform a pop on an edge where o_valid && i_ready: increment rd_ptr modulo DEPTH.
REQ-020 SHALL be first-word-fall-through: an entry pushed into an empty FIFO at edge N has o_valid high and its fields on o_data/o_seq in the cycle after edge N; there is no same-cycle bypass.
REQ-021 SHALL, on simultaneous push and pop, keep the count unchanged and advance both pointers.
REQ-022 SHALL, when full (count = DEPTH), reject the write because o_ready is low, even if a pop happens in the same cycle.
REQ-023 SHALL, when empty, drive o_data = IDLE_VAL and o_seq = 0; a pop request while empty SHALL be ignored.
REQ-024 SHALL increment o_drop_cnt on every edge with i_valid && !o_ready, saturating at 255.
REQ-025 SHALL leave the data of a rejected write unstored and seq_ctr unchanged.
REQ-026 SHALL keep o_count equal to the number of accepted pushes minus the number of performed pops since reset.

Reset
REQ-027 SHALL, while i_rst_n is low, immediately clear wr_ptr, rd_ptr, count, seq_ctr and o_drop_cnt, and set every stored record to {IDLE_VAL, 0}.
REQ-028 SHALL drive these outputs during reset: o_valid = 0, o_ready = 1, o_data = IDLE_VAL, o_seq = 0, o_count = 0, o_drop_cnt = 0.
REQ-029 SHALL discard all entries when reset is asserted mid-operation; the first push after reset release SHALL carry seq 0.

Structure
REQ-030 SHALL place the default constants (DATA_W_DEF = 8, DEPTH_DEF = 4, SEQ_W_DEF = 4) and the default-width record typedef rec_t in package struct_out_pkg.
REQ-031 SHALL declare the parameter-width record typedef locally in the module.
REQ-032 SHALL contain exactly one sub-module, struct_out_fifo_ctl, holding the pointers, count, full/empty logic and the drop counter; the record storage stays in the parent.

Verification
REQ-033 SHALL cover reset: assert i_rst_n low mid-stream with 3 entries held -> o_valid = 0, o_data = 8'hFF, o_count = 0 immediately; the next push after release carries o_seq = 0.
REQ-034 SHALL cover fill and drain: push 8'h11, 8'h22, 8'h33, 8'h44 with i_ready = 0 -> o_ready = 0 and o_count = 4; then drain -> read 11/22/33/44 with seq 0/1/2/3; afterwards o_data = 8'hFF.
REQ-035 SHALL cover write while full: full FIFO, i_valid high for 3 cycles and i_ready = 0 -> o_drop_cnt = 3, contents unchanged, the next accepted push carries seq 4.
REQ-036 SHALL cover simultaneous push and pop: count = 2, push and pop every cycle for 10 cycles -> o_count stays 2, output order preserved, seq wraps from 15 to 0.
REQ-037 SHALL cover drop-counter saturation: 300 rejected writes -> o_drop_cnt = 255.
REQ-038 SHALL cover a non-default configuration: DATA_W = 16, DEPTH = 8 -> 8 entries accepted, o_count = 8, empty o_data = 16'hFFFF.

Source files
------------

// File: rtl/struct_out_pkg.sv
// Shared defaults and the default-width record layout for the struct output FIFO.
package struct_out_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int SEQ_W_DEF  = 4;

  typedef struct {
    logic [DATA_W_DEF-1:0] data;
    logic [SEQ_W_DEF-1:0]  seq;
  } rec_t;
endpackage

// File: rtl/struct_out_fifo_ctl.sv
// Pointer, occupancy, sequence-stamp and drop-count bookkeeping for struct_out_fifo.
module struct_out_fifo_ctl #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          space,
  output logic          avail,
  output logic          push,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [SEQ_W-1:0] seq,
  output logic [CW-1:0] count,
  output logic [7:0]    drop_cnt
);
  logic pop;

  // Flags come only from the registered count, never from the request inputs.
  assign space = count < CW'(DEPTH);
  assign avail = count != '0;
  assign push  = wr_req && space;
  assign pop   = rd_req && avail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      seq      <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq    <= seq + SEQ_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (wr_req && !space && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/struct_out_fifo.sv
// First-word-fall-through FIFO of {data, seq} records with idle value and drop counter.
module struct_out_fifo
  import struct_out_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int SEQ_W  = SEQ_W_DEF,
  parameter logic [DATA_W-1:0] IDLE_VAL = '1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [DATA_W-1:0]          i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [DATA_W-1:0]          o_data,
  output logic [SEQ_W-1:0]           o_seq,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [7:0]                 o_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [SEQ_W-1:0]  seq;
  } rec_p_t;

  rec_p_t            mem [DEPTH];
  rec_p_t            head;
  logic              push;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [SEQ_W-1:0]  seq;

  struct_out_fifo_ctl #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .AW(AW), .CW(CW)) u_ctl (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .wr_req   (i_valid),
    .rd_req   (i_ready),
    .space    (o_ready),
    .avail    (o_valid),
    .push     (push),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .seq      (seq),
    .count    (o_count),
    .drop_cnt (o_drop_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].data <= IDLE_VAL;
        mem[i].seq  <= '0;
      end
    end else if (push) begin
      mem[wr_ptr].data <= i_data;
      mem[wr_ptr].seq  <= seq;
    end
  end

  // Popped slots keep stale data, so the idle value is muxed in whenever empty.
  assign head   = mem[rd_ptr];
  assign o_data = o_valid ? head.data : IDLE_VAL;
  assign o_seq  = o_valid ? head.seq  : '0;
endmodule

// File: tb/tb_struct_out_fifo.sv
// Bench for struct_out_fifo: directed tables and hand sequences plus random traffic vs a queue model.
module tb_struct_out_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid, ready;
  logic [7:0]  data;
  logic        o_ready, o_valid;
  logic [7:0]  o_data;
  logic [3:0]  o_seq;
  logic [2:0]  o_count;
  logic [7:0]  o_drop_cnt;

  logic        valid2, ready2;
  logic [15:0] data2;
  logic        o_ready2, o_valid2;
  logic [15:0] o_data2;
  logic [3:0]  o_seq2;
  logic [3:0]  o_count2;
  logic [7:0]  o_drop_cnt2;

  struct_out_fifo dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_seq(o_seq),
    .i_ready(ready), .o_count(o_count), .o_drop_cnt(o_drop_cnt)
  );

  struct_out_fifo #(.DATA_W(16), .DEPTH(8)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .i_data(data2),
    .o_ready(o_ready2), .o_valid(o_valid2), .o_data(o_data2), .o_seq(o_seq2),
    .i_ready(ready2), .o_count(o_count2), .o_drop_cnt(o_drop_cnt2)
  );

  typedef struct { logic [7:0] data; logic [3:0] seq; } mrec_t;
  mrec_t q[$];
  int    mseq, mdrop;
  int    errors = 0, checks = 0;

  typedef struct {
    logic       v; logic [7:0] d; logic r;
    logic       exp_ready; int exp_count; logic [7:0] exp_data; logic [3:0] exp_seq;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(o_valid), 32'(q.size() > 0));
    chk("ready", 32'(o_ready), 32'(q.size() < 4));
    chk("count", 32'(o_count), 32'(q.size()));
    chk("data",  32'(o_data),  (q.size() > 0) ? 32'(q[0].data) : 32'hFF);
    chk("seq",   32'(o_seq),   (q.size() > 0) ? 32'(q[0].seq)  : 32'h0);
    chk("drop",  32'(o_drop_cnt), 32'(mdrop));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit    pv, pr;
    mrec_t tmp;
    valid = v; data = d; ready = r;
    @(posedge clk);
    pv = q.size() > 0;
    pr = q.size() < 4;
    if (r && pv) tmp = q.pop_front();
    if (v && pr) begin
      q.push_back('{d, 4'(mseq)});
      mseq = (mseq + 1) % 16;
    end
    if (v && !pr && mdrop < 255) mdrop++;
    #1;
    check_model();
  endtask

  task automatic do_reset();
    valid = 0; ready = 0; data = 0;
    valid2 = 0; ready2 = 0; data2 = 0;
    rst_n = 0;
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_data",  32'(o_data), 32'hFF);
    chk("rst_seq",   32'(o_seq), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_drop",  32'(o_drop_cnt), 0);
    q.delete(); mseq = 0; mdrop = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // Fill and drain with fixed expectations.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1, 8'h11, 4'd0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 2, 8'h11, 4'd0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 3, 8'h11, 4'd0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 8'h11, 4'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 3, 8'h22, 4'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 2, 8'h33, 4'd2};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 8'h44, 4'd3};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'hFF, 4'd0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("tbl_ready", 32'(o_ready), 32'(tbl[i].exp_ready));
      chk("tbl_count", 32'(o_count), 32'(tbl[i].exp_count));
      chk("tbl_data",  32'(o_data),  32'(tbl[i].exp_data));
      chk("tbl_seq",   32'(o_seq),   32'(tbl[i].exp_seq));
    end

    // Reset mid-stream with three entries held.
    for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0);
    do_reset();
    step(1, 8'hAB, 0);
    chk("post_rst_seq", 32'(o_seq), 0);
    chk("post_rst_data", 32'(o_data), 32'hAB);

    // Writes while full are dropped; next accepted push gets seq 4.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h50 + 8'(i), 0);
    for (int i = 0; i < 3; i++) step(1, 8'hEE, 0);
    chk("full_drop3", 32'(o_drop_cnt), 3);
    chk("full_head", 32'(o_data), 32'h50);
    step(0, 0, 1);
    step(1, 8'h55, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("after_full_data", 32'(o_data), 32'h55);
    chk("after_full_seq", 32'(o_seq), 4);
    step(0, 0, 1);

    // Push and pop every cycle at count 2, crossing the seq wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(i), 0);
      step(0, 0, 1);
    end
    step(1, 8'h80, 0);
    step(1, 8'h81, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'h90 + 8'(i), 1);
      chk("pp_count", 32'(o_count), 2);
    end
    chk("pp_head_seq", 32'(o_seq), 2);

    // Random traffic, first biased full then biased empty.
    for (int i = 0; i < 400; i++) begin
      if (i < 200) step(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0);
      else         step(($urandom % 4) == 0, 8'($urandom), ($urandom % 4) != 0);
    end

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(i), 0);
    for (int i = 0; i < 300; i++) step(1, 8'hDD, 0);
    chk("drop_sat", 32'(o_drop_cnt), 255);

    // Wider, deeper instance.
    do_reset();
    chk("w16_empty_data", 32'(o_data2), 32'hFFFF);
    for (int i = 0; i < 8; i++) begin
      valid2 = 1; data2 = 16'hA000 + 16'(i);
      step(0, 0, 0);
    end
    valid2 = 0;
    chk("w16_count", 32'(o_count2), 8);
    chk("w16_ready", 32'(o_ready2), 0);
    chk("w16_head", 32'(o_data2), 32'hA000);
    for (int i = 0; i < 8; i++) begin
      chk("w16_order", 32'(o_data2), 32'hA000 + 32'(i));
      chk("w16_seq", 32'(o_seq2), 32'(i));
      ready2 = 1;
      step(0, 0, 0);
    end
    ready2 = 0;
    chk("w16_drained_valid", 32'(o_valid2), 0);
    chk("w16_drained_data", 32'(o_data2), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
